// File: rtl/vadd_sched.sv
// Round-robin scheduler sharing one fixed-latency vector-add datapath between
// NREQ requesters. Each accepted operand is issued the following cycle and its
// owner id travels down a tag pipeline so the result can be steered back.
module vadd_sched #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned LAT   = 2,
    parameter int unsigned LANES = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic [NREQ-1:0]               i_req_valid,
    output logic [NREQ-1:0]               o_req_ready,
    input  logic [NREQ*LANES*WIDTH-1:0]   i_req_data,
    output logic                          o_dp_valid,
    output logic [LANES*WIDTH-1:0]        o_dp_a,
    input  logic [LANES*WIDTH-1:0]        i_dp_y,
    output logic [NREQ-1:0]               o_rsp_valid,
    output logic [LANES*WIDTH-1:0]        o_rsp_data,
    output logic                          o_busy
);

    localparam int unsigned VW  = LANES * WIDTH;
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned IW  = IDW + 1;

    logic [IDW-1:0] r_ptr;
    logic           r_dp_valid;
    logic [VW-1:0]  r_dp_a;
    logic [LAT:0]   r_tag_v;
    logic [IDW-1:0] r_tag_id [0:LAT];
    logic [NREQ-1:0] r_rsp_valid;
    logic [VW-1:0]  r_rsp_data;

    logic [IW-1:0]   w_idx;
    logic [IDW-1:0]  w_win;
    logic            w_found;
    logic [NREQ-1:0] w_grant;
    logic            w_accept;
    logic [VW-1:0]   w_sel_data;
    logic [NREQ-1:0] w_rsp_onehot;

    // Find the first valid requester scanning upward from the pointer, wrapping mod NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + IW'(k);
            if (w_idx >= IW'(NREQ)) begin
                w_idx = w_idx - IW'(NREQ);
            end
            if (!w_found && i_req_valid[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[IDW-1:0];
            end
        end
    end

    // Grant is independent of the requester's own ready, so no loop through req_valid.
    always_comb begin
        w_grant = '0;
        if (i_enable && w_found && !i_reset) begin
            w_grant[w_win] = 1'b1;
        end
    end

    assign o_req_ready = w_grant;
    assign w_accept    = |(i_req_valid & w_grant);
    assign w_sel_data  = i_req_data[VW*w_win +: VW];

    // Pointer advance past the winner and operand issue register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_ptr      <= '0;
            r_dp_valid <= 1'b0;
            r_dp_a     <= '0;
        end else begin
            r_dp_valid <= w_accept;
            if (w_accept) begin
                r_dp_a <= w_sel_data;
                r_ptr  <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
            end
        end
    end

    // Owner tags shift alongside the datapath; stage LAT lines up with a valid dp_y.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_tag_v <= '0;
            for (int k = 0; k <= LAT; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            r_tag_v     <= {r_tag_v[LAT-1:0], w_accept};
            r_tag_id[0] <= w_win;
            for (int k = 1; k <= LAT; k++) begin
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    // Decode the owner id of the operation leaving the datapath.
    always_comb begin
        w_rsp_onehot = '0;
        w_rsp_onehot[r_tag_id[LAT]] = 1'b1;
    end

    // Register the datapath result and pulse the owner's response strobe.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= r_tag_v[LAT] ? w_rsp_onehot : '0;
            if (r_tag_v[LAT]) begin
                r_rsp_data <= i_dp_y;
            end
        end
    end

    assign o_dp_valid  = r_dp_valid;
    assign o_dp_a      = r_dp_a;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_busy      = (|r_tag_v) | (|r_rsp_valid);

endmodule

// File: tb/tb_vadd_sched.sv
// Directed bench for vadd_sched with a two-cycle datapath model adding
// {+2,-4,+5,-3} per lane (lane 0 first).
module tb_vadd_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [127:0] req_data;
    logic        dp_valid;
    logic [31:0] dp_a;
    logic [31:0] dp_y;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;

    logic [31:0] p1 = '0;
    logic [31:0] p2 = '0;

    int n_vec = 0;
    int n_bad = 0;

    vadd_sched #(.NREQ(4), .LAT(2), .LANES(4), .WIDTH(8)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_enable    (enable),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_data  (req_data),
        .o_dp_valid  (dp_valid),
        .o_dp_a      (dp_a),
        .i_dp_y      (dp_y),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f_vec(input logic [31:0] a);
        logic [31:0] kc;
        logic [31:0] y;
        kc = 32'hFD_05_FC_02;
        for (int l = 0; l < 4; l++) y[l*8 +: 8] = a[l*8 +: 8] + kc[l*8 +: 8];
        return y;
    endfunction

    function automatic logic [3:0] oh(input int n);
        return 4'(1) << n;
    endfunction

    // Datapath model: result appears two cycles after the operand.
    always @(posedge clk) begin
        p1 <= f_vec(dp_a);
        p2 <= p1;
    end
    assign dp_y = p2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; req_valid = 4'b1111; req_data = '0;
        step();
        #3;
        n_vec++; if (req_ready !== 4'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0000", req_ready); end
        n_vec++; if (dp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dp_valid got %b want 0", dp_valid); end
        n_vec++; if (dp_a !== 32'h0) begin n_bad++; $display("FAIL rst_dp_a got %h want 0", dp_a); end
        n_vec++; if (rsp_valid !== 4'b0) begin n_bad++; $display("FAIL rst_rsp_valid got %b want 0000", rsp_valid); end
        n_vec++; if (rsp_data !== 32'h0) begin n_bad++; $display("FAIL rst_rsp_data got %h want 0", rsp_data); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        step();
        rst = 1'b0; req_valid = '0;
    endtask

    task automatic test_single_op();
        req_data = '0;
        req_data[32 +: 32] = 32'h01_00_02_FC;
        req_valid = 4'b0010;
        #3;
        n_vec++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL single_ready got %b want 0010", req_ready); end
        step(); req_valid = '0; #3;
        n_vec++; if (dp_valid !== 1'b1) begin n_bad++; $display("FAIL single_dp_valid got %b want 1", dp_valid); end
        n_vec++; if (dp_a !== 32'h01_00_02_FC) begin n_bad++; $display("FAIL single_dp_a got %h want 010002fc", dp_a); end
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b want 1", busy); end
        step(); #3;
        n_vec++; if (dp_valid !== 1'b0) begin n_bad++; $display("FAIL single_dp_idle got %b want 0", dp_valid); end
        step(); #3;
        n_vec++; if (rsp_valid !== 4'b0) begin n_bad++; $display("FAIL single_rsp_early got %b want 0000", rsp_valid); end
        step(); #3;
        n_vec++; if (rsp_valid !== 4'b0010) begin n_bad++; $display("FAIL single_rsp_valid got %b want 0010", rsp_valid); end
        n_vec++; if (rsp_data !== 32'hFE_05_FE_FE) begin n_bad++; $display("FAIL single_rsp_data got %h want fe05fefe", rsp_data); end
        step(); #3;
        n_vec++; if (rsp_valid !== 4'b0) begin n_bad++; $display("FAIL single_rsp_once got %b want 0000", rsp_valid); end
        n_vec++; if (rsp_data !== 32'hFE_05_FE_FE) begin n_bad++; $display("FAIL single_rsp_hold got %h want fe05fefe", rsp_data); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end got %b want 0", busy); end
        step();
    endtask

    // Pointer is 2 here (last grant was requester 1).
    task automatic test_sparse();
        logic [3:0] exp_rdy [0:2];
        int         exp_id  [0:2];
        exp_rdy[0] = 4'b0001; exp_rdy[1] = 4'b0010; exp_rdy[2] = 4'b0001;
        exp_id[0] = 0; exp_id[1] = 1; exp_id[2] = 0;
        req_data = '0;
        req_data[0 +: 32]  = 32'h04030201;
        req_data[32 +: 32] = 32'h40302010;
        for (int c = 0; c < 8; c++) begin
            req_valid = (c < 3) ? 4'b0011 : 4'b0000;
            #3;
            if (c < 3) begin
                n_vec++;
                if (req_ready !== exp_rdy[c]) begin
                    n_bad++; $display("FAIL sparse_ready c=%0d got %b want %b", c, req_ready, exp_rdy[c]);
                end
            end
            if (c >= 4 && c <= 6) begin
                n_vec++;
                if (rsp_valid !== oh(exp_id[c-4])) begin
                    n_bad++; $display("FAIL sparse_rsp c=%0d got %b want %b", c, rsp_valid, oh(exp_id[c-4]));
                end
                n_vec++;
                if (rsp_data !== f_vec(req_data[exp_id[c-4]*32 +: 32])) begin
                    n_bad++; $display("FAIL sparse_data c=%0d got %h want %h", c, rsp_data,
                                      f_vec(req_data[exp_id[c-4]*32 +: 32]));
                end
            end
            step();
        end
    endtask

    // Pointer is 1 here; only requester 3 asks.
    task automatic test_wrap();
        req_data = '0;
        req_data[96 +: 32] = 32'h02_FE_00_FF;
        req_valid = 4'b1000;
        #3;
        n_vec++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL wrap_ready got %b want 1000", req_ready); end
        step(); req_valid = '0;
        step(); step(); step(); #3;
        n_vec++; if (rsp_valid !== 4'b1000) begin n_bad++; $display("FAIL wrap_rsp_valid got %b want 1000", rsp_valid); end
        n_vec++; if (rsp_data !== 32'hFF_03_FC_01) begin n_bad++; $display("FAIL wrap_rsp_data got %h want ff03fc01", rsp_data); end
        step();
    endtask

    task automatic test_round_robin();
        int cnt [0:3];
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            req_data[i*32 +: 32] = {4{8'(8'h11 * (i + 1))}};
        end
        apply_reset();
        for (int k = 0; k < 44; k++) begin
            req_valid = (k < 40) ? 4'b1111 : 4'b0000;
            #3;
            if (k < 40) begin
                n_vec++;
                if (req_ready !== oh(k % 4)) begin
                    n_bad++; $display("FAIL rr_ready k=%0d got %b want %b", k, req_ready, oh(k % 4));
                end
                for (int i = 0; i < 4; i++) if (req_ready[i]) cnt[i]++;
            end
            if (k >= 4) begin
                n_vec++;
                if (rsp_valid !== oh((k - 4) % 4) ||
                    rsp_data !== f_vec(req_data[((k - 4) % 4)*32 +: 32])) begin
                    n_bad++; $display("FAIL rr_rsp k=%0d got %b/%h want %b/%h", k, rsp_valid, rsp_data,
                                      oh((k - 4) % 4), f_vec(req_data[((k - 4) % 4)*32 +: 32]));
                end
            end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (cnt[i] !== 10) begin n_bad++; $display("FAIL rr_share req=%0d got %0d want 10", i, cnt[i]); end
        end
    endtask

    task automatic test_enable_gating();
        int pulses;
        pulses = 0;
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            req_valid = 4'b1111;
            enable = (c < 3);
            #3;
            n_vec++;
            if (req_ready !== ((c < 3) ? oh(c) : 4'b0000)) begin
                n_bad++; $display("FAIL en_ready c=%0d got %b want %b", c, req_ready, (c < 3) ? oh(c) : 4'b0);
            end
            n_vec++;
            if (rsp_valid !== ((c >= 4 && c <= 6) ? oh(c - 4) : 4'b0000)) begin
                n_bad++; $display("FAIL en_rsp c=%0d got %b want %b", c, rsp_valid,
                                  (c >= 4 && c <= 6) ? oh(c - 4) : 4'b0);
            end
            n_vec++;
            if (busy !== (c >= 1 && c <= 6)) begin
                n_bad++; $display("FAIL en_busy c=%0d got %b want %b", c, busy, (c >= 1 && c <= 6));
            end
            if (rsp_valid != 4'b0) pulses++;
            step();
        end
        n_vec++;
        if (pulses !== 3) begin n_bad++; $display("FAIL en_pulses got %0d want 3", pulses); end
        enable = 1'b1; req_valid = '0;
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        req_data = '0;
        req_data[0 +: 32] = 32'hA5A5A5A5;
        req_valid = 4'b0001;
        #3;
        n_vec++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_ready got %b want 0001", req_ready); end
        step();
        req_valid = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({req_ready, dp_valid, dp_a, rsp_valid, rsp_data, busy} !== 74'h0) begin
            n_bad++; $display("FAIL mid_outs rdy=%b dpv=%b dpa=%h rspv=%b rspd=%h busy=%b want all 0",
                              req_ready, dp_valid, dp_a, rsp_valid, rsp_data, busy);
        end
        step(); step(); step();
        rst = 1'b0; req_valid = '0;
        for (int c = 0; c < 8; c++) begin
            #3;
            n_vec++;
            if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
                n_bad++; $display("FAIL mid_ghost c=%0d rsp got %b busy %b want 0000/0", c, rsp_valid, busy);
            end
            step();
        end
        req_valid = 4'b1111;
        #3;
        n_vec++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_ptr got %b want 0001", req_ready); end
        step();
        req_valid = '0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; req_valid = '0; req_data = '0;
        test_reset();
        test_single_op();
        test_sparse();
        test_wrap();
        test_round_robin();
        test_enable_gating();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
